misr_32b: RTL and testbench
===========================

# misr_32b

Multiple-input signature register (MISR) that compacts a stream of 32-bit result words into one 32-bit signature and compares it against an expected value. It is the response end of our datapath self-test. A stimulus source drives vectors through a unit under test, such as the 32-bit logic gates. This block absorbs the outputs, counts them, and reports pass/fail once the programmed number of words has been accepted.

## Interface
- WIDTH, 32: data and signature width.
- POLY, 32'h04C11DB7: feedback polynomial; bit 32 is implicit.
- SEED, 32'h00000000: signature value loaded at `start`.
- CNT_W, 16: width of the vector counter.

- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle pulse that arms a run.
- num_vec, input, CNT_W: number of words to absorb; sampled with `start`.
- exp_sig, input, WIDTH: expected signature; must be stable from `start` until `done`.
- in_valid, input, 1: `in_data` is valid.
- in_data, input, WIDTH: result word from the unit under test.
- in_ready, output, 1: block accepts a word this cycle.
- busy, output, 1: run in progress.
- done, output, 1: run complete; held until the next `start` or reset.
- pass, output, 1: `done && (sig == exp_sig)`.
- sig, output, WIDTH: current signature.

## Operation
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - `start` with `num_vec` > 0: `sig` <= SEED, `cnt` <= `num_vec`, go to CAPTURE.
  - `start` with `num_vec` == 0: `sig` <= SEED, go to DONE.
- CAPTURE:
  - `in_ready` = 1, `busy` = 1.
  - Accept when `in_valid && in_ready`.
  - On accept: `sig` <= `{sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ in_data`, and `cnt` <= `cnt` - 1.
  - Accept with `cnt` == 1: go to DONE.
  - `start` is ignored in CAPTURE.
- DONE:
  - `done` = 1; `sig` is frozen.
  - `start` re-arms exactly as in IDLE.
- `in_valid` outside CAPTURE has no effect.
- Counter arithmetic is unsigned; no wrap is possible because the counter only decrements from a nonzero value down to 1.

## Timing
- Reset values: `sig` = 0, `in_ready` = 0, `busy` = 0, `done` = 0, `pass` = 0, state = IDLE.
- Reset mid-run returns everything to the reset values on that edge.
- `start` seen at edge N: `in_ready` = 1 from cycle N+1.
- Each accept updates `sig` on the same edge; throughput is one word per cycle.
- Final accept at edge M: `done` = 1 and `busy` = 0 from cycle M+1.
- `pass` is combinational from `done`, `sig` and `exp_sig`.
- Gaps in `in_valid` stall without changing `sig` or `cnt`.

## Configuration
- `MISR_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort` in CAPTURE: go to IDLE next cycle; `sig` keeps its value; `done` stays 0.
  - `abort` has priority over a simultaneous accept; that word is dropped.
  - `abort` in other states is ignored.
- `MISR_ABORT_EN` undefined: the port does not exist and runs cannot be cancelled except by reset.

## Structure
- Package `misr_pkg`:
  - State enum: IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2.
  - Default POLY and SEED constants.
- Sub-module `misr_step`: combinational next-signature function with inputs `sig`, `data` and `POLY`. It is reused by the bench's reference model.

## Test plan
- Reset, then idle 3 cycles -> `sig` = 0, `done` = 0, `in_ready` = 0, `pass` = 0.
- `start`, `num_vec` = 1, `in_data` = 32'h11111111, `exp_sig` = 32'h11111111 -> `done` = 1 and `pass` = 1 one cycle after the accept.
- `start`, `num_vec` = 3, data 32'h11111111, 32'hFFFFFFFF, 32'h00000000 with 2 idle cycles between words:
  - `sig` steps through 32'h11111111, 32'hDDDDDDDD, 32'hBF7AA60D.
  - `exp_sig` = 32'hBF7AA60D -> `pass` = 1.
  - `exp_sig` = 32'hBF7AA60C -> `pass` = 0 with `done` = 1.
- `start` with `num_vec` = 0 -> `done` = 1 next cycle, `sig` = SEED, and `in_ready` never rises.
- `start` pulsed again mid-CAPTURE -> ignored, count unchanged.
- `rst_n` low mid-CAPTURE after 1 of 3 words -> all outputs return to reset values next cycle.
- With `MISR_ABORT_EN`: `abort` asserted together with the 2nd word -> IDLE, `sig` = 32'h11111111, `done` = 0.

Source files
------------

// File: rtl/misr_pkg.sv
// misr_pkg: shared definitions for the misr_32b signature block.
//   - misr_state_e : FSM state encoding (IDLE, CAPTURE, DONE)
//   - MISR_POLY_DEFAULT / MISR_SEED_DEFAULT : default feedback polynomial and seed
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } misr_state_e;

  // CRC-32 polynomial; the x^32 term is implicit.
  localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED_DEFAULT = 32'h00000000;

endpackage

// File: rtl/misr_step.sv
// misr_step: combinational next-signature function of the MISR.
//   next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ data
// Ports:
//   sig_i  [WIDTH-1:0] : current signature
//   data_i [WIDTH-1:0] : word being absorbed
//   next_o [WIDTH-1:0] : signature after absorbing data_i
module misr_step #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = misr_pkg::MISR_POLY_DEFAULT
) (
  input  logic [WIDTH-1:0] sig_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] fb;

  // Feedback is applied when the bit shifted out (the implicit x^WIDTH term) is set.
  assign fb     = sig_i[WIDTH-1] ? POLY : '0;
  assign next_o = {sig_i[WIDTH-2:0], 1'b0} ^ fb ^ data_i;

endmodule

// File: rtl/misr_32b.sv
// misr_32b: multiple-input signature register. Compacts a stream of result
// words into one signature and compares it against an expected value.
//
// Optional feature macro: MISR_ABORT_EN adds an 'abort' input that cancels a
// run in CAPTURE (back to IDLE, signature kept, done stays low).
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// in_ready is high exactly while the FSM is in CAPTURE, and does not depend
// on in_valid. in_valid outside CAPTURE is ignored.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start, num_vec    : arm a run absorbing num_vec words (num_vec sampled with start)
//   exp_sig           : expected signature, held stable from start until done
//   in_valid, in_data : result word input; in_ready = word accepted this cycle
//   busy, done, pass  : run in progress / run complete / done and sig == exp_sig
//   sig               : current signature
//   state_o           : FSM state, for observation
`ifdef MISR_ABORT_EN
//   abort             : cancel the current run (CAPTURE only)
`endif
module misr_32b
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY_DEFAULT,
  parameter logic [WIDTH-1:0] SEED  = MISR_SEED_DEFAULT,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] exp_sig,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef MISR_ABORT_EN
  input  logic             abort,
`endif
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig,
  output logic [1:0]       state_o
);

  misr_state_e      state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sig_next;
  logic             accept;

  misr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .sig_i  (sig_q),
    .data_i (in_data),
    .next_o (sig_next)
  );

  assign accept = in_valid && (state_q == CAPTURE);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d = SEED;
          if (num_vec != '0) begin
            cnt_d   = num_vec;
            state_d = CAPTURE;
          end else begin
            state_d = DONE;
          end
        end
      end
      CAPTURE: begin
`ifdef MISR_ABORT_EN
        // Abort wins over a simultaneous accept: that word is dropped.
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        if (accept) begin
          sig_d = sig_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready = (state_q == CAPTURE);
  assign busy     = (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign pass     = done && (sig_q == exp_sig);
  assign sig      = sig_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_misr_32b.sv
module tb_misr_32b;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'h00000000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic [31:0] exp_sig;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] sig;
  logic [1:0]  state_o;
`ifdef MISR_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_sig;

  typedef struct packed {
    logic [15:0]       n;
    logic [3:0][31:0]  data;
    logic [3:0]        gap;
    logic [31:0]       es;
    logic [31:0]       fin;
    logic              p;
  } vec_t;

  vec_t rows[5];

  misr_32b dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_vec  (num_vec),
    .exp_sig  (exp_sig),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef MISR_ABORT_EN
    .abort    (abort),
`endif
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .sig      (sig),
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model / checks ----------------
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [31:0] d);
    logic [31:0] r;
    r = {s[30:0], 1'b0} ^ d;
    if (s[31]) r = r ^ POLY;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] n, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [3:0] gap, input logic [31:0] es,
                              input logic [31:0] fin, input logic p);
    vec_t v;
    v.n = n; v.data = '0;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.gap = gap; v.es = es; v.fin = fin; v.p = p;
    return v;
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start_run(input logic [15:0] n, input logic [31:0] es);
    start = 1'b1; num_vec = n; exp_sig = es;
    model_sig = SEED;
    exp_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int waited;
    waited = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    model_sig = model_step(model_sig, d);
    exp_q.push_back(model_sig);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    if (exp_q.size() > 0) check("sig_step", sig, exp_q.pop_front());
    if (gap > 0) begin
      repeat (gap) @(negedge clk);
      check("sig_stall", sig, model_sig);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] rdata[8];
    int          rn;
    logic [31:0] rfin;

    rst_n = 1'b0; start = 1'b0; num_vec = '0; exp_sig = '0;
    in_valid = 1'b0; in_data = '0; model_sig = SEED;
`ifdef MISR_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sig", sig, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    rows[0] = mk(16'd1, 32'h11111111, 32'h0, 32'h0, 4'd0, 32'h11111111, 32'h11111111, 1'b1);
    rows[1] = mk(16'd3, 32'h11111111, 32'hFFFFFFFF, 32'h00000000, 4'd2, 32'hBF7AA60D, 32'hBF7AA60D, 1'b1);
    rows[2] = mk(16'd3, 32'h11111111, 32'hFFFFFFFF, 32'h00000000, 4'd2, 32'hBF7AA60C, 32'hBF7AA60D, 1'b0);
    rows[3] = mk(16'd0, 32'h0, 32'h0, 32'h0, 4'd0, 32'h00000000, 32'h00000000, 1'b1);
    rows[4] = mk(16'd2, 32'h80000000, 32'h00000000, 32'h0, 4'd0, 32'h04C11DB7, 32'h04C11DB7, 1'b1);

    for (int i = 0; i < 5; i++) begin
      start_run(rows[i].n, rows[i].es);
      if (rows[i].n == 0) begin
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_sig", sig, SEED);
        for (int k = 0; k < 3; k++) begin
          check("zero_in_ready", {31'd0, in_ready}, 32'd0);
          @(negedge clk);
        end
      end else begin
        check("start_in_ready", {31'd0, in_ready}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        for (int j = 0; j < int'(rows[i].n); j++) begin
          check("not_done_yet", {31'd0, done}, 32'd0);
          send_word(rows[i].data[j], int'(rows[i].gap));
        end
      end
      check("end_done", {31'd0, done}, 32'd1);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_sig", sig, rows[i].fin);
      check("end_pass", {31'd0, pass}, {31'd0, rows[i].p});
      @(negedge clk);
    end

    // Random run: expected signature from the bench model, expect pass.
    rn = $urandom_range(4, 8);
    rfin = SEED;
    for (int j = 0; j < rn; j++) begin
      rdata[j] = $urandom;
      rfin = model_step(rfin, rdata[j]);
    end
    start_run(16'(rn), rfin);
    for (int j = 0; j < rn; j++) send_word(rdata[j], int'($urandom_range(0, 2)));
    check("rand_done", {31'd0, done}, 32'd1);
    check("rand_pass", {31'd0, pass}, 32'd1);
    @(negedge clk);

    // start pulsed mid-CAPTURE must be ignored (count stays 3).
    start_run(16'd3, 32'hBF7AA60D);
    send_word(32'h11111111, 0);
    start = 1'b1; num_vec = 16'd1;
    @(negedge clk);
    start = 1'b0; num_vec = 16'd0;
    check("midstart_busy", {31'd0, busy}, 32'd1);
    check("midstart_sig", sig, 32'h11111111);
    send_word(32'hFFFFFFFF, 0);
    check("midstart_not_done", {31'd0, done}, 32'd0);
    send_word(32'h00000000, 0);
    check("midstart_done", {31'd0, done}, 32'd1);
    check("midstart_pass", {31'd0, pass}, 32'd1);
    @(negedge clk);

    // Reset mid-CAPTURE after 1 of 3 words.
    start_run(16'd3, 32'hBF7AA60D);
    send_word(32'h11111111, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sig", sig, 32'h0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_pass", {31'd0, pass}, 32'd0);
    check("midrst_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);

`ifdef MISR_ABORT_EN
    // Abort together with the 2nd word: word dropped, back to IDLE.
    start_run(16'd3, 32'hBF7AA60D);
    send_word(32'h11111111, 0);
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("abort_sig", sig, 32'h11111111);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
